// File: rtl/fifo_sync_flags_if.sv
// fifo_sync_flags_if
//
// Purpose: groups the data/handshake and status signals of fifo_sync_flags
// into one bundle so producers, consumers and the FIFO share a single port.
//
// Signals:
//   flush         producer -> FIFO  synchronous clear of pointers, count, error bits
//   write_data    producer -> FIFO  word to enqueue (DATA_WIDTH)
//   write_enable  producer -> FIFO  write request
//   read_enable   consumer -> FIFO  read request (pop)
//   read_data     FIFO -> consumer  head-of-queue word (DATA_WIDTH)
//   full, empty, almost_full, almost_empty   occupancy flags
//   count         FIFO -> user      occupancy 0..2**ADDRESS_WIDTH (ADDRESS_WIDTH+1 bits)
//   overflow      FIFO -> user      sticky: a write was rejected
//   underflow     FIFO -> user      sticky: a read was rejected
//
// Modports: master = the side that drives requests, slave = the FIFO.

interface fifo_sync_flags_if #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 4
);
    logic                     flush;
    logic [DATA_WIDTH-1:0]    write_data;
    logic                     write_enable;
    logic                     read_enable;
    logic [DATA_WIDTH-1:0]    read_data;
    logic                     full;
    logic                     empty;
    logic                     almost_full;
    logic                     almost_empty;
    logic [ADDRESS_WIDTH:0]   count;
    logic                     overflow;
    logic                     underflow;

    modport master (
        output flush, write_data, write_enable, read_enable,
        input  read_data, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  flush, write_data, write_enable, read_enable,
        output read_data, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/fifo_sync_flags.sv
// fifo_sync_flags
//
// Purpose: single-clock FIFO with full/empty/almost flags, occupancy count,
// sticky overflow/underflow bits and a synchronous flush.
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous, active-high reset
//   bus   fifo_sync_flags_if.slave (data, handshake and status signals)
//
// Parameters:
//   DATA_WIDTH          word width
//   ADDRESS_WIDTH       pointer index width
//   FIFO_DEPTH          must equal 2**ADDRESS_WIDTH
//   ALMOST_FULL_LEVEL   almost_full  when count >= this
//   ALMOST_EMPTY_LEVEL  almost_empty when count <= this
//
// Compile-time option:
//   FIFO_REGISTERED_READ_EN  defined: read_data is a register loaded on each
//                            accepted read (data one cycle after the pop),
//                            cleared only by rst.
//                            undefined (default): first-word fall-through,
//                            read_data shows the head word, 0 when empty.

module fifo_sync_flags #(
    parameter int DATA_WIDTH         = 8,
    parameter int ADDRESS_WIDTH      = 4,
    parameter int FIFO_DEPTH         = 2**ADDRESS_WIDTH,
    parameter int ALMOST_FULL_LEVEL  = FIFO_DEPTH - 1,
    parameter int ALMOST_EMPTY_LEVEL = 1
) (
    input  logic               clk,
    input  logic               rst,
    fifo_sync_flags_if.slave   bus
);

    localparam logic [ADDRESS_WIDTH:0] AF_LEVEL = ALMOST_FULL_LEVEL[ADDRESS_WIDTH:0];
    localparam logic [ADDRESS_WIDTH:0] AE_LEVEL = ALMOST_EMPTY_LEVEL[ADDRESS_WIDTH:0];

    // The MSB of each pointer is a wrap bit, so equal indices can be told
    // apart as "empty" (wrap bits equal) or "full" (wrap bits differ).
    logic [ADDRESS_WIDTH:0]   wr_ptr;
    logic [ADDRESS_WIDTH:0]   rd_ptr;
    logic [DATA_WIDTH-1:0]    mem [0:FIFO_DEPTH-1];

    logic [ADDRESS_WIDTH-1:0] wr_index;
    logic [ADDRESS_WIDTH-1:0] rd_index;
    logic [ADDRESS_WIDTH:0]   occupancy;
    logic                     is_full;
    logic                     is_empty;
    logic                     read_accept;
    logic                     write_accept;
    logic                     overflow_q;
    logic                     underflow_q;

    assign wr_index  = wr_ptr[ADDRESS_WIDTH-1:0];
    assign rd_index  = rd_ptr[ADDRESS_WIDTH-1:0];
    assign occupancy = wr_ptr - rd_ptr;
    assign is_empty  = (wr_ptr == rd_ptr);
    assign is_full   = (wr_ptr[ADDRESS_WIDTH] != rd_ptr[ADDRESS_WIDTH]) &&
                       (wr_index == rd_index);

    // Flush drops both requests outright. A write into a full FIFO is still
    // taken when the head is popped in the same cycle, since a slot frees up.
    assign read_accept  = !bus.flush && bus.read_enable && !is_empty;
    assign write_accept = !bus.flush && bus.write_enable && (!is_full || read_accept);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (bus.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (write_accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (read_accept) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (bus.flush) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (bus.write_enable && !write_accept) begin
                overflow_q <= 1'b1;
            end
            if (bus.read_enable && !read_accept) begin
                underflow_q <= 1'b1;
            end
        end
    end

    // No reset on the storage so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (write_accept) begin
            mem[wr_index] <= bus.write_data;
        end
    end

`ifdef FIFO_REGISTERED_READ_EN
    logic [DATA_WIDTH-1:0] read_data_q;

    // When full with a simultaneous read and write, rd_index equals wr_index;
    // the non-blocking memory write means the old head word is captured here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            read_data_q <= '0;
        end else if (read_accept) begin
            read_data_q <= mem[rd_index];
        end
    end

    assign bus.read_data = read_data_q;
`else
    assign bus.read_data = is_empty ? '0 : mem[rd_index];
`endif

    // All flags come from the registered pointers only.
    assign bus.full         = is_full;
    assign bus.empty        = is_empty;
    assign bus.count        = occupancy;
    assign bus.almost_full  = (occupancy >= AF_LEVEL);
    assign bus.almost_empty = (occupancy <= AE_LEVEL);
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;

endmodule

// File: doc/fifo_sync_flags.md
# fifo_sync_flags

Parametrised single-clock FIFO with status flags, occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error bits and a synchronous flush. Drop-in successor for the plain pointer-pair FIFO on the datapath between stream producers and consumers, e.g. between the DSC pixel front-end and the encoder core. Read-port style (fall-through or registered) is selected at compile time.

## Interface
- DATA_WIDTH, 8: word width in bits.
- ADDRESS_WIDTH, 4: pointer index width.
- FIFO_DEPTH, 2**ADDRESS_WIDTH: word count; must equal 2**ADDRESS_WIDTH.
- ALMOST_FULL_LEVEL, FIFO_DEPTH-1: almost_full asserts when count >= this value.
- ALMOST_EMPTY_LEVEL, 1: almost_empty asserts when count <= this value.

- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  synchronous clear of pointers, count and error bits.
- write_data  in  DATA_WIDTH  data to enqueue.
- write_enable  in  1  write request.
- read_enable  in  1  read request (pop).
- read_data  out  DATA_WIDTH  head-of-queue data (see Configuration).
- full  out  1  count == FIFO_DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= ALMOST_FULL_LEVEL.
- almost_empty  out  1  count <= ALMOST_EMPTY_LEVEL.
- count  out  ADDRESS_WIDTH+1  current occupancy, 0..FIFO_DEPTH.
- overflow  out  1  sticky: a write was rejected.
- underflow  out  1  sticky: a read was rejected.

## Operation
- Read and write pointers are ADDRESS_WIDTH+1 bits; the MSB is the wrap bit. count = wr_ptr - rd_ptr (modulo 2**(ADDRESS_WIDTH+1)); full when indices match and wrap bits differ; empty when pointers are equal.
- Write accepted iff write_enable && (!full || read accepted this cycle). Accepted write stores write_data at mem[wr_ptr index]; wr_ptr += 1.
- Read accepted iff read_enable && !empty. rd_ptr += 1.
- Full, read+write in the same cycle: both accepted, count unchanged, no overflow.
- Empty, read+write in the same cycle: write accepted, read rejected, underflow set, count becomes 1.
- Rejected write: memory and pointers untouched; overflow <= 1. Rejected read: pointers untouched; underflow <= 1.
- overflow/underflow hold until rst or flush.
- flush has priority over write_enable and read_enable in the same cycle: pointers and error bits go to 0; memory contents are not cleared; requests in that cycle are dropped and do not set error bits.
- Pointer wrap: index wraps FIFO_DEPTH-1 -> 0 and toggles the wrap bit; no data loss across wrap.
- Flags are decoded from registered pointers only; no combinational path from enables to flags.
- Memory has no reset (block-RAM inferable).

## Timing
- Reset values: count 0, empty 1, almost_empty 1, full 0, almost_full 0, overflow 0, underflow 0, read_data 0.
- Flags, count and error bits update on the clock edge that accepts or rejects the request and are visible in the following cycle.
- Write-to-read latency: a word written on edge N is readable (empty deasserts) after edge N.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous); queued data is discarded.

## Configuration
- FIFO_REGISTERED_READ_EN defined: read_data is a register loaded with mem[rd_ptr index] on every edge where a read is accepted; data appears the cycle after the read_enable edge; read_data holds its value otherwise and is reset to 0 by rst only (not by flush).
- Not defined (default): first-word fall-through; read_data = mem[rd_ptr index] combinationally when !empty, and 0 when empty; read_enable acknowledges the presented word.

## Test plan
Parameters DATA_WIDTH=8, ADDRESS_WIDTH=2, ALMOST_FULL_LEVEL=3, ALMOST_EMPTY_LEVEL=1, both macro settings.
- Reset, idle -> count 0, empty 1, almost_empty 1, full 0, read_data 0, error bits 0.
- Write 0x11,0x22,0x33,0x44 -> count 1,2,3,4; almost_full at count 3; full at 4; then read four -> 0x11..0x44 in order (fall-through: same cycle; registered: one cycle later); empty 1.
- Full, write 0x55 alone -> overflow 1, count 4, next reads still 0x11..0x44; simultaneous read+write when full -> count 4, no overflow, 0x55 emerges last.
- Empty, read_enable alone -> underflow 1, count 0; empty with read+write of 0xA5 -> count 1, underflow 1, next read returns 0xA5.
- Six write/read pairs wrapping pointers twice -> data order preserved, count never exceeds 4.
- Count 3 with flush+write same cycle -> count 0, empty 1, overflow/underflow cleared; rst asserted mid-stream -> all outputs at reset values before next edge.
